audio_sample_feeder: RTL and testbench
======================================

Name: audio_sample_feeder

Overview:
- Upstream stage of sigma_delta_dac: buffers signed PCM samples from a producer (CPU/Wishbone bridge, I2S receiver) in a small FIFO.
- Releases one sample per sample-rate tick, applies 8-bit volume and converts to offset-binary unsigned.
- Drives the DAC's data_in, holding the value constant between ticks.

Parameters:
- IN_BITS, 16, signed PCM input width.
- OUT_BITS, 18, output width; must equal the DAC BITS; constraint OUT_BITS <= IN_BITS+8.
- SAMPLE_DIV_LOG2, 9, sample period = 2**SAMPLE_DIV_LOG2 clk cycles (512 at 24.576 MHz gives 48 kHz).
- FIFO_DEPTH_LOG2, 3, FIFO depth = 8 entries.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run tick counter / consume samples
- s_valid  in  1  producer sample valid
- s_ready  out  1  FIFO can accept (not full)
- s_data  in  IN_BITS  signed two's-complement sample
- volume  in  8  linear gain, volume/256 (0 = mute, 255 = about -0.03 dB)
- underrun_clr  in  1  clears sticky underrun flag
- data_out  out  OUT_BITS  unsigned offset-binary to DAC data_in
- sample_tick  out  1  one-cycle pulse at each sample period boundary
- fifo_level  out  FIFO_DEPTH_LOG2+1  current occupancy 0..DEPTH
- underrun  out  1  sticky: tick occurred with FIFO empty

Behaviour:
- Reset (async, rst=1): FIFO empty, fifo_level=0, s_ready=1 (after reset only), tick counter=0, sample_tick=0, hold register=0, underrun=0, data_out=MIDSCALE (1<<(OUT_BITS-1), 0x20000 by default).
- Push:
  - Accepted on a rising edge where s_valid && s_ready.
  - s_ready = !full, combinational from the registered count.
  - When full, no push occurs, even if a pop happens in the same cycle.
- Tick counter:
  - Free-running SAMPLE_DIV_LOG2-bit counter while enable=1; wraps to 0.
  - sample_tick is high for the cycle in which counter == all-ones.
  - enable=0: counter is forced to 0 and sample_tick=0; data_out keeps following hold/volume.
- Pop:
  - On the edge ending a sample_tick cycle: if the FIFO is non-empty, the head goes to the hold register and the pointer advances.
  - If the FIFO is empty, hold keeps its previous value (no click) and underrun is set.
- Simultaneous events:
  - Push and pop in the same cycle with FIFO not full: level unchanged.
  - Push into an empty FIFO during a tick cycle: the tick sees empty, so underrun is set and the pushed sample is stored for the next tick.
  - underrun_clr and a new underrun in the same cycle: set wins.
- Datapath (registered every cycle):
  - product = signed(hold) * signed({1'b0, volume}), width IN_BITS+9.
  - scaled = product >>> (IN_BITS+8-OUT_BITS), truncated to OUT_BITS.
  - data_out <= scaled ^ MIDSCALE.
- Latency:
  - data_out reflects a new sample 2 edges after the sample_tick cycle.
  - Volume change is visible 1 edge later.
- Reset mid-operation: all state returns to reset values immediately; FIFO contents are discarded.

Optional Feature:
- Macro: AUDIO_FEEDER_LINEAR_INTERP_EN.
- Defined:
  - At each pop, cur <= target, target <= new sample, step <= (new - target) >>> SAMPLE_DIV_LOG2 (IN_BITS+1 signed).
  - Every clock between ticks, cur += step; cur, not hold, feeds the multiplier.
  - Adds one sample period of latency.
  - On underrun, step <= 0.
- Undefined: zero-order hold as above; no interpolation registers are synthesised.

Decomposition:
- Package audio_pkg:
  - OUT_BITS default, MIDSCALE constant, sample_t typedef (signed IN_BITS), volume_t (8-bit).
  - Shared with sigma_delta_dac wrapper and mixer blocks.
- Sub-module sync_fifo (parameterised width/depth; push/pop/full/empty/level), reusable by other audio blocks.

Test Plan:
- Reset, no input, enable=1, volume=255 -> data_out=0x20000 and underrun=1 after the first tick; underrun_clr clears it.
- Push 0x7FFF, volume=255 -> data_out=0x3FDFC 2 cycles after the tick. Push 0x8000 -> 0x00200. Volume=0 -> 0x20000 one cycle later.
- Push 9 samples back-to-back with enable=0 -> 8 accepted, s_ready=0, fifo_level=8. Enable -> one pop per 512 cycles, level decrements, s_ready reasserts.
- Push coincident with a tick into an empty FIFO -> underrun=1, level=1, and the sample appears at the next tick.
- Assert rst mid-stream with 5 entries queued -> immediately data_out=0x20000, level=0, s_ready=1.
- With AUDIO_FEEDER_LINEAR_INTERP_EN: samples 0 then 512, SAMPLE_DIV_LOG2=9, volume=255 -> cur ramps by 1 per clock; data_out is monotonic across the period.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio widths, midscale constant and sample/volume types
package audio_pkg;

  localparam int AUDIO_IN_BITS  = 16;
  localparam int AUDIO_OUT_BITS = 18;

  // Offset-binary zero point for the default DAC width.
  localparam logic [AUDIO_OUT_BITS-1:0] MIDSCALE = AUDIO_OUT_BITS'(1) << (AUDIO_OUT_BITS - 1);

  typedef logic signed [AUDIO_IN_BITS-1:0] sample_t;
  typedef logic [7:0]                      volume_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop, full/empty and occupancy level
module sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  // Count never exceeds DEPTH, so its MSB alone marks the full state.
  assign full    = count[DEPTH_LOG2];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // Storage array: unoccupied entries are don't-care, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; a refused push (full) never moves anything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (!do_push && do_pop) count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/audio_sample_feeder.sv
// rtl/audio_sample_feeder.sv - PCM FIFO, sample-rate release, volume and offset-binary output (option: AUDIO_FEEDER_LINEAR_INTERP_EN)
module audio_sample_feeder
  import audio_pkg::*;
#(
  parameter int IN_BITS         = AUDIO_IN_BITS,
  parameter int OUT_BITS        = AUDIO_OUT_BITS,
  parameter int SAMPLE_DIV_LOG2 = 9,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [IN_BITS-1:0]         s_data,
  input  logic [7:0]                 volume,
  input  logic                       underrun_clr,
  output logic [OUT_BITS-1:0]        data_out,
  output logic                       sample_tick,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       underrun
);

  localparam int PW    = IN_BITS + 9;
  localparam int SHIFT = IN_BITS + 8 - OUT_BITS;
  localparam logic [OUT_BITS-1:0]        MID      = OUT_BITS'(1) << (OUT_BITS - 1);
  localparam logic [SAMPLE_DIV_LOG2-1:0] TICK_ONE = SAMPLE_DIV_LOG2'(1);

  logic [SAMPLE_DIV_LOG2-1:0] tick_cnt;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [IN_BITS-1:0]         fifo_head;
  logic signed [IN_BITS-1:0]  mult_src;
  logic signed [PW-1:0]       product;

  assign sample_tick = enable && (&tick_cnt);
  assign s_ready     = !fifo_full;

  // The FIFO ignores pops while empty, so the tick can be wired straight in.
  sync_fifo #(
    .WIDTH      (IN_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .pop   (sample_tick),
    .wdata (s_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Sample-period counter: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tick_cnt <= '0;
    else if (!enable) tick_cnt <= '0;
    else              tick_cnt <= tick_cnt + TICK_ONE;
  end

  // Sticky underrun: a tick finding the FIFO empty beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            underrun <= 1'b0;
    else if (sample_tick && fifo_empty) underrun <= 1'b1;
    else if (underrun_clr)              underrun <= 1'b0;
  end

`ifdef AUDIO_FEEDER_LINEAR_INTERP_EN
  logic signed [IN_BITS:0] interp_cur;
  logic signed [IN_BITS:0] interp_target;
  logic signed [IN_BITS:0] interp_step;
  logic signed [IN_BITS:0] interp_diff;

  assign interp_diff = $signed({fifo_head[IN_BITS-1], fifo_head}) - interp_target;
  assign mult_src    = IN_BITS'(interp_cur);

  // Linear ramp: each tick restarts from the previous target and slopes toward the new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interp_cur    <= '0;
      interp_target <= '0;
      interp_step   <= '0;
    end else if (sample_tick) begin
      interp_cur <= interp_target;
      if (!fifo_empty) begin
        interp_target <= $signed({fifo_head[IN_BITS-1], fifo_head});
        interp_step   <= interp_diff >>> SAMPLE_DIV_LOG2;
      end else begin
        interp_step   <= '0;
      end
    end else if (enable) begin
      interp_cur <= interp_cur + interp_step;
    end
  end
`else
  logic signed [IN_BITS-1:0] hold;

  assign mult_src = hold;

  // Zero-order hold: keeps the last sample through an underrun so the output does not click.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             hold <= '0;
    else if (sample_tick && !fifo_empty) hold <= $signed(fifo_head);
  end
`endif

  assign product = PW'(mult_src) * PW'($signed({1'b0, volume}));

  // Output stage: gain, rescale to DAC width, flip sign bit for offset binary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out <= MID;
    else     data_out <= OUT_BITS'(product >>> SHIFT) ^ MID;
  end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb/tb_audio_sample_feeder.sv - randomized bench for audio_sample_feeder against a queue-based model
module tb_audio_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [7:0]  volume;
  logic        underrun_clr;
  logic [17:0] data_out;
  logic        sample_tick;
  logic [3:0]  fifo_level;
  logic        underrun;

  audio_sample_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .volume       (volume),
    .underrun_clr (underrun_clr),
    .data_out     (data_out),
    .sample_tick  (sample_tick),
    .fifo_level   (fifo_level),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: queued samples, cycles into the current sample period,
  // the sample currently held, the registered output and the sticky flag.
  int q[$];
  int phase;
  int m_hold;
  int m_dout;
  bit m_under;

  function automatic void model_reset();
    q.delete();
    phase   = 0;
    m_hold  = 0;
    m_dout  = 'h20000;
    m_under = 0;
  endfunction

  function automatic void model_clock();
    bit     tick;
    bit     accept;
    bit     was_empty;
    longint p;
    longint s;
    tick      = enable && (phase == 511);
    accept    = s_valid && (q.size() < 8);
    was_empty = (q.size() == 0);
    p = longint'(m_hold) * longint'(volume);
    s = p >>> 6;
    m_dout = int'((s & 64'h3FFFF) ^ 64'h20000);
    if (tick) begin
      if (was_empty) m_under = 1;
      else           m_hold  = q.pop_front();
    end else if (underrun_clr) begin
      m_under = 0;
    end
    if (accept) q.push_back(int'($signed(s_data)));
    phase = enable ? (phase + 1) % 512 : 0;
  endfunction

  task automatic cyc();
    #1;
    check("s_ready",     s_ready,     q.size() < 8);
    check("sample_tick", sample_tick, enable && (phase == 511));
    check("fifo_level",  fifo_level,  q.size());
    check("underrun",    underrun,    m_under);
    check("data_out",    data_out,    m_dout);
    @(posedge clk);
    if (rst) model_reset();
    else     model_clock();
    @(negedge clk);
  endtask

  task automatic run_to_tick();
    int n = 0;
    while (phase != 511 && n < 600) begin
      cyc();
      n++;
    end
    check("tick_reached", phase, 511);
    repeat (2) cyc();
  endtask

  initial begin
    model_reset();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    volume = 8'd255; underrun_clr = 1'b0;
    @(negedge clk);
    repeat (3) cyc();
    check("rst_data_out", data_out, 'h20000);
    check("rst_level", fifo_level, 0);
    rst = 1'b0;

    // Idle with enable: first tick finds the FIFO empty.
    enable = 1'b1;
    repeat (515) cyc();
    check("underrun_first_tick", underrun, 1);
    underrun_clr = 1'b1; cyc(); underrun_clr = 1'b0;
    check("underrun_cleared", underrun, 0);

    // Full-scale positive and negative samples at max volume, then mute.
    s_valid = 1'b1; s_data = 16'h7FFF; cyc(); s_valid = 1'b0;
    run_to_tick();
    check("pos_full_scale", data_out, 'h3FDFC);
    s_valid = 1'b1; s_data = 16'h8000; cyc(); s_valid = 1'b0;
    run_to_tick();
    check("neg_full_scale", data_out, 'h00200);
    volume = 8'd0; cyc();
    check("mute", data_out, 'h20000);
    volume = 8'd255;

    // Fill past capacity while stopped, then drain at the sample rate.
    enable = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_data = 16'($urandom);
      cyc();
    end
    s_valid = 1'b0;
    check("fill_level", fifo_level, 8);
    check("fill_ready", s_ready, 0);
    enable = 1'b1;
    repeat (8 * 512 + 20) cyc();
    check("drained_level", fifo_level, 0);

    // Push landing in the tick cycle of an empty FIFO.
    underrun_clr = 1'b1; cyc(); underrun_clr = 1'b0;
    while (phase != 511) cyc();
    s_valid = 1'b1; s_data = 16'h1234; cyc(); s_valid = 1'b0;
    check("coincident_underrun", underrun, 1);
    check("coincident_level", fifo_level, 1);
    run_to_tick();
    check("coincident_sample", data_out, 'h24887);

    // Asynchronous reset with five queued entries.
    enable = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 16'($urandom);
      cyc();
    end
    s_valid = 1'b0;
    check("pre_reset_level", fifo_level, 5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_data_out", data_out, 'h20000);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_ready", s_ready, 1);
    check("async_rst_underrun", underrun, 0);
    model_reset();
    @(negedge clk);
    cyc();
    rst = 1'b0;

    // Randomized traffic: overfeeding then starving the FIFO.
    enable = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (i < 10000) s_valid = ($urandom_range(0, 255) == 0);
      else           s_valid = ($urandom_range(0, 1023) == 0);
      s_data = 16'($urandom);
      underrun_clr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 499) == 0) volume = 8'($urandom);
      if ($urandom_range(0, 1999) == 0) enable = ~enable;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
